quantum_rr_arbiter: RTL and testbench

QUANTUM_RR_ARBITER -- requirements
Module: quantum_rr_arbiter

---
 rtl/quantum_rr_arbiter.sv | 156 +++++++++++++++
 tb/tb_quantum_rr_arbiter.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/quantum_rr_arbiter.sv
// Round-robin bus arbiter with a fixed grant time slice (quantum).
// A one-cycle dead SWITCH state separates consecutive owners; busy_i pins the current owner.
module quantum_rr_arbiter #(
    parameter int NUM_MASTERS  = 4,
    parameter int QUANTUM_TIME = 16,
    localparam int IDX_W = $clog2(NUM_MASTERS),
    localparam int CNT_W = $clog2(QUANTUM_TIME + 1)
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [NUM_MASTERS-1:0] req_i,
    input  logic                   busy_i,
    output logic [NUM_MASTERS-1:0] grant_o,
    output logic [IDX_W-1:0]       grant_idx_o,
    output logic                   grant_valid_o,
    output logic                   quantum_tick_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_SWITCH = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0]       LAST_CNT = CNT_W'(QUANTUM_TIME - 1);
    localparam logic [NUM_MASTERS-1:0] ONE_HOT0 = NUM_MASTERS'(1);

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       owner_q, owner_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   expired_q, expired_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic                   valid_q, valid_d;

    logic                   others_req;
    logic                   owner_req;
    logic                   last_cycle;

    // First asserted request at ptr, ptr+1, ... wrapping at NUM_MASTERS.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_MASTERS-1:0] req,
                                                 input logic [IDX_W-1:0]       ptr);
        logic [IDX_W-1:0] sel;
        logic             found;
        int               idx;
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            idx = (int'(ptr) + i) % NUM_MASTERS;
            if (!found && req[idx]) begin
                sel   = IDX_W'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        return (int'(idx) == NUM_MASTERS - 1) ? '0 : idx + 1'b1;
    endfunction

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        expired_d  = expired_q;
        others_req = |(req_i & ~(ONE_HOT0 << owner_q));
        owner_req  = req_i[owner_q];
        last_cycle = (cnt_q == LAST_CNT);

        unique case (state_q)
            ST_IDLE: begin
                cnt_d     = '0;
                expired_d = 1'b0;
                if (|req_i) begin
                    state_d = ST_GRANT;
                    owner_d = rr_pick(req_i, ptr_q);
                end
            end
            ST_GRANT: begin
                if (busy_i) begin
                    // Owner keeps the bus; only the quantum bookkeeping moves.
                    if (expired_q) begin
                        if (!others_req) begin
                            expired_d = 1'b0;
                            cnt_d     = '0;
                        end
                    end else if (last_cycle) begin
                        if (others_req) expired_d = 1'b1;
                        else            cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (!owner_req || ((expired_q || last_cycle) && others_req)) begin
                    state_d   = ST_SWITCH;
                    ptr_d     = next_idx(owner_q);
                    owner_d   = '0;
                    cnt_d     = '0;
                    expired_d = 1'b0;
                end else if (expired_q || last_cycle) begin
                    expired_d = 1'b0;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SWITCH: begin
                cnt_d     = '0;
                expired_d = 1'b0;
                if (|req_i) begin
                    state_d = ST_GRANT;
                    owner_d = rr_pick(req_i, ptr_q);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                owner_d   = '0;
                cnt_d     = '0;
                expired_d = 1'b0;
            end
        endcase

        valid_d = (state_d == ST_GRANT);
        grant_d = valid_d ? (ONE_HOT0 << owner_d) : '0;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            owner_q   <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            expired_q <= 1'b0;
            grant_q   <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            expired_q <= expired_d;
            grant_q   <= grant_d;
            valid_q   <= valid_d;
        end
    end

    assign grant_o        = grant_q;
    assign grant_idx_o    = owner_q;
    assign grant_valid_o  = valid_q;
    // Held counter while expired must not re-fire the tick.
    assign quantum_tick_o = (state_q == ST_GRANT) && !expired_q && (cnt_q == LAST_CNT);

endmodule

// File: tb/tb_quantum_rr_arbiter.sv
// Directed bench for quantum_rr_arbiter with NUM_MASTERS=4, QUANTUM_TIME=4.
module tb_quantum_rr_arbiter;

    localparam int N = 4;
    localparam int Q = 4;

    logic         clk_i = 1'b0;
    logic         reset_i = 1'b0;
    logic [N-1:0] req_i = '0;
    logic         busy_i = 1'b0;
    logic [N-1:0] grant_o;
    logic [1:0]   grant_idx_o;
    logic         grant_valid_o;
    logic         quantum_tick_o;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [N-1:0] req;
        logic         busy;
        logic [N-1:0] grant;
        logic         tick;
        string        name;
    } vec_t;

    vec_t tbl[$];

    quantum_rr_arbiter #(.NUM_MASTERS(N), .QUANTUM_TIME(Q)) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .req_i         (req_i),
        .busy_i        (busy_i),
        .grant_o       (grant_o),
        .grant_idx_o   (grant_idx_o),
        .grant_valid_o (grant_valid_o),
        .quantum_tick_o(quantum_tick_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input string name, input logic [N-1:0] g, input logic t);
        logic [1:0] idx;
        idx = '0;
        for (int i = 0; i < N; i++) if (g[i]) idx = 2'(i);
        check({name, ".grant"}, 8'(grant_o), 8'(g));
        check({name, ".idx"},   8'(grant_idx_o), 8'(idx));
        check({name, ".valid"}, 8'(grant_valid_o), 8'(|g));
        check({name, ".tick"},  8'(quantum_tick_o), 8'(t));
    endtask

    task automatic step(input logic [N-1:0] r, input logic b, input logic [N-1:0] g,
                        input logic t, input string name);
        req_i  = r;
        busy_i = b;
        @(posedge clk_i);
        #1;
        check_outputs(name, g, t);
    endtask

    function automatic void add(input logic [N-1:0] r, input logic b, input logic [N-1:0] g,
                                input logic t, input string name);
        vec_t v;
        v.req = r; v.busy = b; v.grant = g; v.tick = t; v.name = name;
        tbl.push_back(v);
    endfunction

    initial begin
        // Idle after reset, then a single request and its voluntary release.
        for (int i = 0; i < 5; i++) add(4'b0000, 1'b0, 4'b0000, 1'b0, "idle");
        add(4'b0010, 1'b0, 4'b0010, 1'b0, "single_grant");
        add(4'b0000, 1'b0, 4'b0000, 1'b0, "single_switch");
        add(4'b0000, 1'b0, 4'b0000, 1'b0, "single_idle");
        // Two requesters alternate every quantum (ptr=2 after owner 1, so owner 0 first).
        for (int r = 0; r < 2; r++) begin
            add(4'b0011, 1'b0, 4'b0001, 1'b0, "pre0_c1");
            add(4'b0011, 1'b0, 4'b0001, 1'b0, "pre0_c2");
            add(4'b0011, 1'b0, 4'b0001, 1'b0, "pre0_c3");
            add(4'b0011, 1'b0, 4'b0001, 1'b1, "pre0_c4");
            add(4'b0011, 1'b0, 4'b0000, 1'b0, "pre0_gap");
            add(4'b0011, 1'b0, 4'b0010, 1'b0, "pre1_c1");
            add(4'b0011, 1'b0, 4'b0010, 1'b0, "pre1_c2");
            add(4'b0011, 1'b0, 4'b0010, 1'b0, "pre1_c3");
            add(4'b0011, 1'b0, 4'b0010, 1'b1, "pre1_c4");
            add(4'b0011, 1'b0, 4'b0000, 1'b0, "pre1_gap");
        end
        // Busy through grant cycles 1-7 stretches owner 0 to cycle 8.
        add(4'b0011, 1'b0, 4'b0001, 1'b0, "busy_c1");
        add(4'b0011, 1'b1, 4'b0001, 1'b0, "busy_c2");
        add(4'b0011, 1'b1, 4'b0001, 1'b0, "busy_c3");
        add(4'b0011, 1'b1, 4'b0001, 1'b1, "busy_c4");
        add(4'b0011, 1'b1, 4'b0001, 1'b0, "busy_c5");
        add(4'b0011, 1'b1, 4'b0001, 1'b0, "busy_c6");
        add(4'b0011, 1'b1, 4'b0001, 1'b0, "busy_c7");
        add(4'b0011, 1'b1, 4'b0001, 1'b0, "busy_c8");
        add(4'b0011, 1'b0, 4'b0000, 1'b0, "busy_c9_switch");
        add(4'b0011, 1'b0, 4'b0010, 1'b0, "busy_c10");
        add(4'b0000, 1'b0, 4'b0000, 1'b0, "busy_release");
        add(4'b0000, 1'b0, 4'b0000, 1'b0, "busy_idle");
        // Sole requester keeps the bus with no gap; tick every 4th cycle.
        for (int c = 0; c < 9; c++)
            add(4'b0100, 1'b0, 4'b0100, 1'((c % Q) == Q - 1), "sole");

        reset_i = 1'b0;
        #1 reset_i = 1'b1;
        #1 check_outputs("reset", 4'b0000, 1'b0);
        @(posedge clk_i);
        #1 reset_i = 1'b0;

        foreach (tbl[i]) step(tbl[i].req, tbl[i].busy, tbl[i].grant, tbl[i].tick, tbl[i].name);

        // Asynchronous reset while owner 2 holds the bus.
        #2 reset_i = 1'b1;
        #1 check_outputs("reset_mid", 4'b0000, 1'b0);
        req_i = 4'b1111;
        @(posedge clk_i);
        #1 reset_i = 1'b0;
        for (int m = 0; m < N; m++) begin
            for (int c = 0; c < Q; c++)
                step(4'b1111, 1'b0, 4'(1 << m), 1'(c == Q - 1), "after_reset");
            step(4'b1111, 1'b0, 4'b0000, 1'b0, "after_reset_gap");
        end

        // Owner drops its request while busy: grant held until busy clears.
        step(4'b0001, 1'b0, 4'b0001, 1'b0, "drop_busy_c1");
        step(4'b0000, 1'b1, 4'b0001, 1'b0, "drop_busy_held");
        step(4'b0000, 1'b1, 4'b0001, 1'b0, "drop_busy_held2");
        step(4'b0000, 1'b0, 4'b0000, 1'b0, "drop_busy_switch");
        step(4'b0000, 1'b0, 4'b0000, 1'b0, "drop_busy_idle");

        // Expired owner whose rival vanishes restarts its quantum (ptr=1 -> owner 1).
        step(4'b0011, 1'b0, 4'b0010, 1'b0, "exp_c1");
        step(4'b0011, 1'b1, 4'b0010, 1'b0, "exp_c2");
        step(4'b0011, 1'b1, 4'b0010, 1'b0, "exp_c3");
        step(4'b0011, 1'b1, 4'b0010, 1'b1, "exp_c4");
        step(4'b0011, 1'b1, 4'b0010, 1'b0, "exp_c5_expired");
        step(4'b0010, 1'b1, 4'b0010, 1'b0, "exp_restart_c1");
        step(4'b0010, 1'b0, 4'b0010, 1'b0, "exp_restart_c2");
        step(4'b0010, 1'b0, 4'b0010, 1'b0, "exp_restart_c3");
        step(4'b0010, 1'b0, 4'b0010, 1'b1, "exp_restart_c4");
        step(4'b0000, 1'b0, 4'b0000, 1'b0, "exp_release");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
